typing_round_checker: RTL and testbench

TYPING_ROUND_CHECKER -- requirements
Module: typing_round_checker

---
 rtl/typing_round_checker_if.sv | 37 +++
 rtl/typing_round_checker.sv | 147 ++++++++++++++
 tb/tb_typing_round_checker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/typing_round_checker_if.sv
// Bundle of round-control inputs and status outputs for the typing round checker.
interface typing_round_checker_if #(
  parameter int MAX_LEN = 12,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int TMR_W   = 32
);
  logic                   key_valid;
  logic [7:0]             key_code;
  logic                   start;
  logic [8*MAX_LEN-1:0]   seq_flat;
  logic [LEN_W-1:0]       seq_len;
  logic                   abort;

  logic [2:0]             state;
  logic                   busy;
  logic                   pass_p;
  logic                   fail_p;
  logic                   err_p;
  logic [LEN_W-1:0]       char_idx;
  logic [7:0]             expected_code;
  logic [CNT_W-1:0]       correct_count;
  logic [CNT_W-1:0]       total_count;
  logic [TMR_W-1:0]       time_left;

  modport master (
    output key_valid, key_code, start, seq_flat, seq_len, abort,
    input  state, busy, pass_p, fail_p, err_p, char_idx, expected_code,
           correct_count, total_count, time_left
  );

  modport slave (
    input  key_valid, key_code, start, seq_flat, seq_len, abort,
    output state, busy, pass_p, fail_p, err_p, char_idx, expected_code,
           correct_count, total_count, time_left
  );
endinterface

// File: rtl/typing_round_checker.sv
// Timed typing round: filters PS/2 scan bytes down to make codes and scores them
// against a latched character sequence under a per-character time budget.
module typing_round_checker #(
  parameter int MAX_LEN        = 12,
  parameter int LEN_W          = 5,
  parameter int CNT_W          = 8,
  parameter int TICKS_PER_CHAR = 50_000_000,
  parameter int TMR_W          = 32,
  parameter int STRICT         = 0
) (
  input logic                   clk,
  input logic                   resetn,
  typing_round_checker_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  state_t               st, st_nxt;
  logic                 brk, brk_nxt, make;
  logic [8*MAX_LEN-1:0] seq, seq_nxt;
  logic [LEN_W-1:0]     len, len_nxt, idx, idx_nxt;
  logic [CNT_W-1:0]     cor, cor_nxt, tot, tot_nxt;
  logic [TMR_W-1:0]     tmr, tmr_nxt;
  logic                 pass_q, pass_nxt, fail_q, fail_nxt, err_q, err_nxt;
  logic                 busy, hit, last, len_ok;
  logic [7:0]           exp_code;

  // Break prefix swallows exactly one following byte; extended prefix is transparent.
  always_comb begin
    brk_nxt = brk;
    make    = 1'b0;
    if (bus.key_valid) begin
      if (bus.key_code == 8'hF0)      brk_nxt = 1'b1;
      else if (brk)                   brk_nxt = 1'b0;
      else if (bus.key_code != 8'hE0) make    = 1'b1;
    end
  end

  assign busy = (st == ARMED) || (st == RUN);

  always_comb begin
    exp_code = 8'h00;
    for (int i = 0; i < MAX_LEN; i++)
      if (busy && (idx == LEN_W'(i))) exp_code = seq[i*8 +: 8];
  end

  assign hit    = make && (bus.key_code == exp_code);
  assign last   = (idx == (len - LEN_W'(1)));
  assign len_ok = (bus.seq_len != '0) && (bus.seq_len <= LEN_W'(MAX_LEN));

  always_comb begin
    st_nxt   = st;
    seq_nxt  = seq;
    len_nxt  = len;
    idx_nxt  = idx;
    cor_nxt  = cor;
    tot_nxt  = tot;
    tmr_nxt  = tmr;
    pass_nxt = 1'b0;
    fail_nxt = 1'b0;
    err_nxt  = 1'b0;
    case (st)
      IDLE, PASS, FAIL: begin
        if (bus.start) begin
          if (len_ok) begin
            st_nxt  = ARMED;
            seq_nxt = bus.seq_flat;
            len_nxt = bus.seq_len;
            idx_nxt = '0;
            cor_nxt = '0;
            tot_nxt = '0;
            tmr_nxt = TMR_W'(bus.seq_len) * TMR_W'(TICKS_PER_CHAR);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ARMED, RUN: begin
        if (bus.abort) begin
          st_nxt = IDLE;
        end else if ((st == RUN) || make) begin
          // The arming keystroke already counts as a RUN cycle, timer included.
          st_nxt  = RUN;
          tmr_nxt = (tmr != '0) ? tmr - TMR_W'(1) : '0;
          if (make && !(&tot)) tot_nxt = tot + CNT_W'(1);
          if (hit) begin
            if (!(&cor)) cor_nxt = cor + CNT_W'(1);
            idx_nxt = idx + LEN_W'(1);
          end
          // Completing the sequence beats a timeout landing on the same edge.
          if (hit && last) begin
            st_nxt   = PASS;
            pass_nxt = 1'b1;
          end else if ((make && !hit && (STRICT != 0)) || (tmr <= TMR_W'(1))) begin
            st_nxt   = FAIL;
            fail_nxt = 1'b1;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st     <= IDLE;
      brk    <= 1'b0;
      seq    <= '0;
      len    <= '0;
      idx    <= '0;
      cor    <= '0;
      tot    <= '0;
      tmr    <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= st_nxt;
      brk    <= brk_nxt;
      seq    <= seq_nxt;
      len    <= len_nxt;
      idx    <= idx_nxt;
      cor    <= cor_nxt;
      tot    <= tot_nxt;
      tmr    <= tmr_nxt;
      pass_q <= pass_nxt;
      fail_q <= fail_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.state         = st;
  assign bus.busy          = busy;
  assign bus.pass_p        = pass_q;
  assign bus.fail_p        = fail_q;
  assign bus.err_p         = err_q;
  assign bus.char_idx      = idx;
  assign bus.expected_code = exp_code;
  assign bus.correct_count = cor;
  assign bus.total_count   = tot;
  assign bus.time_left     = tmr;
endmodule

// File: tb/tb_typing_round_checker.sv
// Directed bench: lenient, strict and narrow-counter instances share one stimulus stream.
module tb_typing_round_checker;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        kv = 1'b0;
  logic [7:0]  kc = 8'h00;
  logic        st = 1'b0;
  logic [95:0] seq = '0;
  logic [4:0]  len = '0;
  logic        ab = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int np0 = 0, nf0 = 0, np1 = 0, nf1 = 0;

  always #5 clk = ~clk;

  typing_round_checker_if #(.MAX_LEN(12), .LEN_W(5), .CNT_W(8), .TMR_W(32)) if0 ();
  typing_round_checker_if #(.MAX_LEN(12), .LEN_W(5), .CNT_W(8), .TMR_W(32)) if1 ();
  typing_round_checker_if #(.MAX_LEN(12), .LEN_W(5), .CNT_W(2), .TMR_W(32)) if2 ();

  assign if0.key_valid = kv; assign if1.key_valid = kv; assign if2.key_valid = kv;
  assign if0.key_code  = kc; assign if1.key_code  = kc; assign if2.key_code  = kc;
  assign if0.start     = st; assign if1.start     = st; assign if2.start     = st;
  assign if0.seq_flat  = seq; assign if1.seq_flat = seq; assign if2.seq_flat = seq;
  assign if0.seq_len   = len; assign if1.seq_len  = len; assign if2.seq_len  = len;
  assign if0.abort     = ab; assign if1.abort     = ab; assign if2.abort     = ab;

  typing_round_checker #(.MAX_LEN(12), .LEN_W(5), .CNT_W(8), .TICKS_PER_CHAR(10),
    .TMR_W(32), .STRICT(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0.slave));
  typing_round_checker #(.MAX_LEN(12), .LEN_W(5), .CNT_W(8), .TICKS_PER_CHAR(10),
    .TMR_W(32), .STRICT(1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1.slave));
  typing_round_checker #(.MAX_LEN(12), .LEN_W(5), .CNT_W(2), .TICKS_PER_CHAR(10),
    .TMR_W(32), .STRICT(0)) dut2 (.clk(clk), .resetn(resetn), .bus(if2.slave));

  always @(negedge clk) begin
    if (if0.pass_p) np0++;
    if (if0.fail_p) nf0++;
    if (if1.pass_p) np1++;
    if (if1.fail_p) nf1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic key(input logic [7:0] c);
    kv = 1'b1; kc = c; step(); kv = 1'b0;
  endtask

  task automatic go(input logic [95:0] s, input logic [4:0] l);
    seq = s; len = l; st = 1'b1; step(); st = 1'b0;
  endtask

  initial begin
    int cyc;
    int p0, f0;
    step(); step();
    chk("rst_state", {29'd0, if0.state}, 32'd0);
    chk("rst_busy", {31'd0, if0.busy}, 32'd0);
    chk("rst_idx", {27'd0, if0.char_idx}, 32'd0);
    chk("rst_tl", if0.time_left, 32'd0);
    chk("rst_cnt", {24'd0, if0.total_count}, 32'd0);
    chk("rst_exp", {24'd0, if0.expected_code}, 32'd0);
    resetn = 1'b1; step();

    // Out-of-range lengths are rejected without leaving IDLE.
    go(96'h1C, 5'd0);
    chk("err_len0", {31'd0, if0.err_p}, 32'd1);
    chk("err_len0_st", {29'd0, if0.state}, 32'd0);
    step();
    chk("err_pulse_once", {31'd0, if0.err_p}, 32'd0);
    go(96'h1C, 5'd13);
    chk("err_len13", {31'd0, if0.err_p}, 32'd1);
    chk("err_len13_st", {29'd0, if0.state}, 32'd0);
    step();

    // "A S D" with break codes interleaved.
    go(96'h23_1B_1C, 5'd3);
    chk("armed_st", {29'd0, if0.state}, 32'd1);
    chk("armed_busy", {31'd0, if0.busy}, 32'd1);
    chk("armed_exp", {24'd0, if0.expected_code}, 32'h1C);
    chk("armed_tl", if0.time_left, 32'd30);
    step(); step(); step();
    chk("armed_frozen", if0.time_left, 32'd30);
    key(8'h1C);
    chk("run_st", {29'd0, if0.state}, 32'd2);
    chk("run_tl", if0.time_left, 32'd29);
    chk("run_idx", {27'd0, if0.char_idx}, 32'd1);
    chk("run_exp", {24'd0, if0.expected_code}, 32'h1B);
    go(96'h1C, 5'd1);
    chk("start_in_run_err", {31'd0, if0.err_p}, 32'd0);
    chk("start_in_run_st", {29'd0, if0.state}, 32'd2);
    chk("start_in_run_idx", {27'd0, if0.char_idx}, 32'd1);
    key(8'hF0); key(8'h1C); key(8'h1B); key(8'hF0); key(8'h1B); key(8'h23);
    chk("asd_pass_p", {31'd0, if0.pass_p}, 32'd1);
    chk("asd_st", {29'd0, if0.state}, 32'd3);
    chk("asd_cor", {24'd0, if0.correct_count}, 32'd3);
    chk("asd_tot", {24'd0, if0.total_count}, 32'd3);
    chk("asd_exp_zero", {24'd0, if0.expected_code}, 32'd0);
    step();
    chk("asd_pass_once", np0, 32'd1);
    chk("asd_strict_st", {29'd0, if1.state}, 32'd3);

    // Wrong key: ignored when lenient, fatal when strict.
    go(96'h1C, 5'd1);
    key(8'h15);
    chk("wk_len_st", {29'd0, if0.state}, 32'd2);
    chk("wk_len_tot", {24'd0, if0.total_count}, 32'd1);
    chk("wk_len_cor", {24'd0, if0.correct_count}, 32'd0);
    chk("wk_str_fail_p", {31'd0, if1.fail_p}, 32'd1);
    chk("wk_str_st", {29'd0, if1.state}, 32'd4);
    key(8'h1C);
    chk("wk_len_pass_p", {31'd0, if0.pass_p}, 32'd1);
    chk("wk_len_cor2", {24'd0, if0.correct_count}, 32'd1);
    chk("wk_len_tot2", {24'd0, if0.total_count}, 32'd2);
    chk("wk_str_tot_hold", {24'd0, if1.total_count}, 32'd1);
    step();

    // Timeout: ARMED waits forever, RUN fails 20 cycles after the first key.
    go(96'h1B_1C, 5'd2);
    f0 = nf0;
    for (int i = 0; i < 40; i++) step();
    chk("armed_no_fail_st", {29'd0, if0.state}, 32'd1);
    chk("armed_no_fail_n", nf0, f0);
    key(8'h1C);
    cyc = 1;
    while (!if0.fail_p && cyc < 40) begin step(); cyc++; end
    chk("tmo_latency", cyc, 32'd20);
    chk("tmo_st", {29'd0, if0.state}, 32'd4);
    chk("tmo_tl", if0.time_left, 32'd0);
    chk("tmo_strict_fail_p", {31'd0, if1.fail_p}, 32'd1);
    step();

    // Final key on the very edge the budget runs out.
    go(96'h1B_1C, 5'd2);
    key(8'h1C);
    for (int i = 0; i < 18; i++) step();
    chk("edge_tl1", if0.time_left, 32'd1);
    f0 = nf0; p0 = np0;
    key(8'h1B);
    chk("edge_pass_p", {31'd0, if0.pass_p}, 32'd1);
    chk("edge_fail_p", {31'd0, if0.fail_p}, 32'd0);
    chk("edge_st", {29'd0, if0.state}, 32'd3);
    step();
    chk("edge_no_fail", nf0, f0);
    chk("edge_one_pass", np0, p0 + 1);

    // Abort beats a coincident correct key.
    go(96'h1B_1C, 5'd2);
    key(8'h1C);
    ab = 1'b1; key(8'h1B); ab = 1'b0;
    chk("abort_st", {29'd0, if0.state}, 32'd0);
    chk("abort_cor", {24'd0, if0.correct_count}, 32'd1);
    chk("abort_tot", {24'd0, if0.total_count}, 32'd1);
    chk("abort_idx", {27'd0, if0.char_idx}, 32'd1);
    chk("abort_pass_p", {31'd0, if0.pass_p}, 32'd0);
    step();

    // Saturation on the 2-bit-counter instance.
    go(96'h1C_1C_1C_1C_1C, 5'd5);
    for (int i = 0; i < 4; i++) key(8'h15);
    for (int i = 0; i < 4; i++) key(8'h1C);
    chk("sat_tot", {30'd0, if2.total_count}, 32'd3);
    chk("sat_cor", {30'd0, if2.correct_count}, 32'd3);
    chk("sat_idx", {27'd0, if2.char_idx}, 32'd4);
    chk("wide_tot", {24'd0, if0.total_count}, 32'd8);
    chk("wide_cor", {24'd0, if0.correct_count}, 32'd4);
    ab = 1'b1; step(); ab = 1'b0;

    // Reset mid-round.
    go(96'h23_1B_1C, 5'd3);
    key(8'h1C); key(8'h1B);
    chk("mid_cor", {24'd0, if0.correct_count}, 32'd2);
    p0 = np0; f0 = nf0;
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("mrst_st", {29'd0, if0.state}, 32'd0);
    chk("mrst_cor", {24'd0, if0.correct_count}, 32'd0);
    chk("mrst_tot", {24'd0, if0.total_count}, 32'd0);
    chk("mrst_idx", {27'd0, if0.char_idx}, 32'd0);
    chk("mrst_tl", if0.time_left, 32'd0);
    chk("mrst_pulses", {30'd0, if0.pass_p, if0.fail_p}, 32'd0);
    step(); step();
    chk("mrst_no_pulse", np0 + nf0, p0 + f0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
